// File: rtl/hangman_pkg.sv
// hangman_pkg: shared state encoding, widths and display colours for the hangman game
package hangman_pkg;

    localparam int PART_W = 3;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LOAD    = 4'd1,
        GALLOWS = 4'd2,
        GUESS   = 4'd3,
        COMPARE = 4'd4,
        CHECK   = 4'd5,
        FILL    = 4'd6,
        MISS    = 4'd7,
        DRAW    = 4'd8,
        OVER    = 4'd9
    } state_t;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_GREEN = 3'b010;

endpackage

// File: rtl/hangman_if.sv
// hangman_if: strobes, status flags and scoreboard signals between control and datapath
import hangman_pkg::*;

interface hangman_if #(
    parameter int SCORE_W = 4
);
    logic                key_valid;
    logic                key_enter;
    logic                graph_loaded;
    logic                match;
    logic                all_filled;
    logic                finish;
    logic                timeout;
    logic                ld;
    logic                ld_g;
    logic                timecount;
    logic                compare;
    logic                fill;
    logic                draw;
    logic                over;
    logic [PART_W-1:0]   part;
    logic [4:0]          word_len;
    logic [SCORE_W-1:0]  p1_score;
    logic [SCORE_W-1:0]  p2_score;
    logic [3:0]          state;

    modport master (
        input  key_valid, key_enter, graph_loaded, match, all_filled, finish, timeout,
        output ld, ld_g, timecount, compare, fill, draw, over,
        output part, word_len, p1_score, p2_score, state
    );

    modport slave (
        output key_valid, key_enter, graph_loaded, match, all_filled, finish, timeout,
        input  ld, ld_g, timecount, compare, fill, draw, over,
        input  part, word_len, p1_score, p2_score, state
    );
endinterface

// File: rtl/hangman_control_sat_counter.sv
// sat_counter: up counter with synchronous clear that sticks at its all-ones maximum
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);
    // count up on i_inc, holding at the top value instead of wrapping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            o_q <= '0;
        else if (i_clr)
            o_q <= '0;
        else if (i_inc && o_q != '1)
            o_q <= o_q + 1'b1;
    end
endmodule

// File: rtl/hangman_control.sv
// hangman_control: game-sequencing FSM issuing datapath strobes and keeping length, misses and scores
import hangman_pkg::*;

module hangman_control #(
    parameter int MAX_LEN    = 16,
    parameter int MAX_MISSES = 6,
    parameter int SCORE_W    = 4
) (
    input  logic      clk,
    input  logic      resetn,
    hangman_if.master bus
);
    state_t             r_state, w_next;
    logic [4:0]         r_len;
    logic [PART_W-1:0]  r_miss, r_part;
    logic               r_filled, r_ld;
    logic [5:0]         r_strb;
    logic               w_key, w_ld, w_last, w_p1_inc, w_p2_inc;

    assign w_key    = bus.key_valid & ~bus.key_enter;
    assign w_ld     = (r_state == LOAD) && w_key && (r_len < 5'(MAX_LEN));
    assign w_last   = (r_miss + 3'd1) == PART_W'(MAX_MISSES);
    assign w_p1_inc = (r_state == DRAW) && bus.finish && w_last;
    assign w_p2_inc = (r_state == FILL) && bus.finish && r_filled;

    // next-state decode; finish is only looked at in the three pass states
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.key_valid) w_next = LOAD;
            LOAD:    if (bus.key_valid && bus.key_enter && r_len != 5'd0) w_next = GALLOWS;
            GALLOWS: if (bus.graph_loaded) w_next = GUESS;
            GUESS:   if (w_key) w_next = COMPARE;
                     else if (bus.timeout) w_next = MISS;
            COMPARE: w_next = CHECK;
            CHECK:   w_next = bus.match ? FILL : MISS;
            FILL:    if (bus.finish) w_next = r_filled ? OVER : GUESS;
            MISS:    w_next = DRAW;
            DRAW:    if (bus.finish) w_next = w_last ? OVER : GUESS;
            OVER:    if (bus.finish) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state, registered strobes and per-round bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_miss   <= '0;
            r_part   <= '0;
            r_filled <= 1'b0;
            r_ld     <= 1'b0;
            r_strb   <= '0;
        end else begin
            r_state  <= w_next;
            r_ld     <= w_ld;
            r_strb   <= {w_next == GALLOWS, w_next == GUESS, w_next == COMPARE,
                         w_next == FILL, w_next == DRAW, w_next == OVER};
            if (w_ld)
                r_len <= r_len + 5'd1;
            if (r_state == CHECK)
                r_filled <= bus.all_filled;
            if (w_next == MISS)
                r_part <= r_miss;
            if (r_state == DRAW && bus.finish)
                r_miss <= r_miss + 3'd1;
            if (w_next == IDLE) begin
                r_len  <= '0;
                r_miss <= '0;
                r_part <= '0;
            end
        end
    end

    sat_counter #(.W(SCORE_W)) u_p1 (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (1'b0),
        .i_inc  (w_p1_inc),
        .o_q    (bus.p1_score)
    );

    sat_counter #(.W(SCORE_W)) u_p2 (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (1'b0),
        .i_inc  (w_p2_inc),
        .o_q    (bus.p2_score)
    );

    assign bus.ld        = r_ld;
    assign bus.ld_g      = r_strb[5];
    assign bus.timecount = r_strb[4];
    assign bus.compare   = r_strb[3];
    assign bus.fill      = r_strb[2];
    assign bus.draw      = r_strb[1];
    assign bus.over      = r_strb[0];
    assign bus.part      = r_part;
    assign bus.word_len  = r_len;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_hangman_control.sv
// tb_hangman_control: randomized game play against an event-level model of length, misses and scores
module tb_hangman_control;
    localparam int MAX_LEN = 16, MAX_MISSES = 6, SW = 4, SMAX = 15;
    localparam logic [6:0] NONE = 7'h00, LDG = 7'h20, TC = 7'h10, CMP = 7'h08,
                           FIL = 7'h04, DRW = 7'h02, OVR = 7'h01;

    logic clk = 1'b0, resetn = 1'b0;
    hangman_if #(.SCORE_W(SW)) bus();

    hangman_control #(.MAX_LEN(MAX_LEN), .MAX_MISSES(MAX_MISSES), .SCORE_W(SW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int m_p1 = 0, m_p2 = 0, m_miss = 0;
    bit done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] strb();
        return {bus.ld, bus.ld_g, bus.timecount, bus.compare, bus.fill, bus.draw, bus.over};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input int s, input logic [6:0] m);
        chk({tag, ".state"}, 32'(bus.state), s);
        chk({tag, ".strobes"}, 32'(strb()), 32'(m));
    endtask

    task automatic do_pass(input string tag, input int s, input logic [6:0] m, input int f, input bit keep);
        for (int i = 0; i <= f; i++) begin
            st(tag, s, m);
            if (i == f) bus.finish = 1'b1;
            tick();
        end
        if (!keep) bus.finish = 1'b0;
    endtask

    task automatic round_end();
        chk("p1_score", 32'(bus.p1_score), m_p1);
        chk("p2_score", 32'(bus.p2_score), m_p2);
        do_pass("over", 9, OVR, bus.finish ? 0 : $urandom_range(0, 3), 1'b0);
        st("idle", 0, NONE);
        chk("idle.word_len", 32'(bus.word_len), 0);
        chk("idle.part", 32'(bus.part), 0);
        done = 1'b1;
    endtask

    task automatic miss_path();
        st("miss", 7, NONE);
        chk("miss.part", 32'(bus.part), m_miss);
        tick();
        chk("draw.part", 32'(bus.part), m_miss);
        m_miss++;
        do_pass("draw", 8, DRW, $urandom_range(0, 4), (m_miss == MAX_MISSES) && ($urandom_range(0, 1) == 1));
        if (m_miss == MAX_MISSES) begin
            m_p1 = (m_p1 < SMAX) ? m_p1 + 1 : SMAX;
            round_end();
        end else
            st("back_guess", 3, TC);
    endtask

    // kind: 0 hit, 1 wrong guess, 2 timeout, 3 key and timeout together, 4 Enter in GUESS
    task automatic guess(input int kind, input bit win);
        if (kind == 2) begin
            bus.timeout = 1'b1;
            tick();
            bus.timeout = 1'b0;
            miss_path();
        end else if (kind == 4) begin
            bus.key_valid = 1'b1;
            bus.key_enter = 1'b1;
            tick();
            bus.key_valid = 1'b0;
            bus.key_enter = 1'b0;
            st("enter_in_guess", 3, TC);
        end else begin
            bus.key_valid = 1'b1;
            bus.timeout   = (kind == 3);
            tick();
            bus.key_valid = 1'b0;
            bus.timeout   = 1'b0;
            st("compare", 4, CMP);
            tick();
            st("check", 5, NONE);
            bus.match      = (kind != 1);
            bus.all_filled = (kind == 1) ? 1'($urandom_range(0, 1)) : win;
            tick();
            bus.match      = 1'b0;
            bus.all_filled = 1'b0;
            if (kind == 1)
                miss_path();
            else begin
                do_pass("fill", 6, FIL, $urandom_range(0, 5), win && ($urandom_range(0, 1) == 1));
                if (win) begin
                    m_p2 = (m_p2 < SMAX) ? m_p2 + 1 : SMAX;
                    round_end();
                end else
                    st("after_fill", 3, TC);
            end
        end
    endtask

    task automatic load_word(input int n, input bit try_empty);
        bus.key_valid = 1'b1;
        bus.key_enter = 1'($urandom_range(0, 1));
        tick();
        bus.key_valid = 1'b0;
        bus.key_enter = 1'b0;
        st("load", 1, NONE);
        chk("load.ld_first", 32'(bus.ld), 0);
        if (try_empty) begin
            bus.key_valid = 1'b1;
            bus.key_enter = 1'b1;
            tick();
            bus.key_valid = 1'b0;
            bus.key_enter = 1'b0;
            st("empty_enter", 1, NONE);
            chk("empty_enter.word_len", 32'(bus.word_len), 0);
        end
        for (int i = 0; i < n; i++) begin
            bus.key_valid = 1'b1;
            tick();
            bus.key_valid = 1'b0;
            chk("key.ld", 32'(bus.ld), (i < MAX_LEN) ? 1 : 0);
            chk("key.word_len", 32'(bus.word_len), (i + 1 < MAX_LEN) ? i + 1 : MAX_LEN);
            tick();
            chk("gap.ld", 32'(bus.ld), 0);
        end
        bus.key_valid = 1'b1;
        bus.key_enter = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        bus.key_enter = 1'b0;
        chk("entered.word_len", 32'(bus.word_len), (n < MAX_LEN) ? n : MAX_LEN);
        for (int i = $urandom_range(0, 12); i > 0; i--) begin
            st("gallows", 2, LDG);
            tick();
        end
        st("gallows", 2, LDG);
        bus.graph_loaded = 1'b1;
        tick();
        bus.graph_loaded = 1'b0;
        st("first_guess", 3, TC);
        m_miss = 0;
        done   = 1'b0;
    endtask

    task automatic random_round(input bit try_empty);
        int g;
        int k;
        load_word($urandom_range(1, 18), try_empty);
        g = 0;
        while (!done) begin
            k = $urandom_range(0, 4);
            g++;
            guess(g > 30 ? 0 : k, (g > 30) || ((k == 0 || k == 3) && $urandom_range(0, 5) == 0));
        end
    endtask

    initial begin
        {bus.key_valid, bus.key_enter, bus.graph_loaded, bus.match,
         bus.all_filled, bus.finish, bus.timeout} = '0;
        #2;
        st("reset", 0, NONE);
        chk("reset.p1", 32'(bus.p1_score), 0);
        chk("reset.p2", 32'(bus.p2_score), 0);
        #10 resetn = 1'b1;
        tick();
        st("post_reset", 0, NONE);
        random_round(1'b1);
        for (int r = 0; r < 10; r++) random_round(1'($urandom_range(0, 1)));
        for (int r = 0; r < 20; r++) begin
            load_word($urandom_range(1, 4), 1'b0);
            while (!done) guess(2, 1'b0);
        end
        chk("p1_saturated", 32'(bus.p1_score), SMAX);
        for (int r = 0; r < 20; r++) begin
            load_word($urandom_range(1, 4), 1'b0);
            guess(3, 1'b1);
        end
        chk("p2_saturated", 32'(bus.p2_score), SMAX);
        for (int r = 0; r < 4; r++) random_round(1'b0);
        load_word(3, 1'b0);
        guess(2, 1'b0);
        guess(1, 1'b0);
        bus.timeout = 1'b1;
        tick();
        bus.timeout = 1'b0;
        tick();
        st("pre_reset_draw", 8, DRW);
        chk("pre_reset_draw.part", 32'(bus.part), 2);
        #2 resetn = 1'b0;
        #1;
        st("async_reset", 0, NONE);
        chk("async_reset.p1", 32'(bus.p1_score), 0);
        chk("async_reset.p2", 32'(bus.p2_score), 0);
        chk("async_reset.part", 32'(bus.part), 0);
        #10 resetn = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
